// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request-side controller in front of a single-port memory.
// Turns a valid/ready request stream into addr/wdata/wr_en/rd_en strobes,
// performs single-beat writes and incrementing (wrapping) burst reads, and
// returns read data on a valid/ready response channel with one memory
// access outstanding at a time.
// Optional feature macro: MEM_REQ_CTRL_STATS_EN adds saturating write/read
// activity counters (stat_wr_cnt, stat_rd_cnt).
module mem_req_ctrl #(
    parameter int AW     = 7,
    parameter int DW     = 8,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [DW-1:0]    req_wdata,
    input  logic [LEN_W-1:0] req_len,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic             mem_wr_en,
    output logic             mem_rd_en,
    input  logic [DW-1:0]    mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_rdata,
    output logic [AW-1:0]    rsp_addr
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_wr_cnt,
    output logic [15:0]      stat_rd_cnt
`endif
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RSP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] beats_q;
    logic [LEN_W-1:0] beats_d;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] lat_d;

    logic [AW-1:0]    mem_addr_d;
    logic [DW-1:0]    mem_wdata_d;
    logic             mem_wr_en_d;
    logic             mem_rd_en_d;
    logic             rsp_valid_d;
    logic [DW-1:0]    rsp_rdata_d;
    logic [AW-1:0]    rsp_addr_d;

    logic             accept;
    logic             rsp_hs;

    // Requests are only taken in IDLE and never while reset is asserted.
    assign req_ready = (state_q == IDLE) && rst;
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    // State and registered outputs; reset clears everything including data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            beats_q   <= '0;
            lat_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            lat_q     <= lat_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wr_en <= mem_wr_en_d;
            mem_rd_en <= mem_rd_en_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_addr  <= rsp_addr_d;
        end
    end

    // Next-state and next-output logic; strobes default low, wdata defaults to 0.
    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        lat_d       = lat_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = '0;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_addr_d  = rsp_addr;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr_d = req_addr;
                    if (req_we) begin
                        state_d     = WR;
                        mem_wr_en_d = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        // First beat is issued on the accept edge itself.
                        state_d     = RD_ISSUE;
                        mem_rd_en_d = 1'b1;
                        beats_d     = req_len;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                lat_d   = '0;
            end
            RD_WAIT: begin
                // mem_addr is still the beat address, so it doubles as rsp_addr.
                if (lat_q == LAT_LAST) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_rdata;
                    rsp_addr_d  = mem_addr;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    if (beats_q != '0) begin
                        // Next beat goes out on the handshake edge; address wraps naturally.
                        state_d     = RD_ISSUE;
                        beats_d     = beats_q - LEN_W'(1);
                        mem_addr_d  = mem_addr + AW'(1);
                        mem_rd_en_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MEM_REQ_CTRL_STATS_EN
    // Saturating activity counters: write strobe cycles and response handshakes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (mem_wr_en && (stat_wr_cnt != 16'hFFFF)) begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
            if (rsp_hs && (stat_rd_cnt != 16'hFFFF)) begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: behavioural 128x8 memory with one-cycle read
// latency, response scoreboard fed when reads are requested, and one task
// per scenario.
module tb_mem_req_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic [3:0] req_len;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = '0;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [6:0] rsp_addr;
`ifdef MEM_REQ_CTRL_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
`endif

    int npass  = 0;
    int ntotal = 0;

    logic [14:0] sb[$];       // expected {rsp_addr, rsp_rdata}, in order
    logic [6:0]  rd_log[$];   // addresses seen with mem_rd_en high
    int          wr_seen  = 0;
    int          rsp_seen = 0;

    logic [7:0]  mem_data [128];
    logic        mem_written [128];
    logic [7:0]  shadow [128];

    mem_req_ctrl #(.AW(7), .DW(8), .LEN_W(4), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr)
`ifdef MEM_REQ_CTRL_STATS_EN
        ,
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [6:0] a);
        return {1'b0, a} ^ 8'hC3;
    endfunction

    // Memory model: synchronous write, registered read (latency 1).
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem_data[mem_addr]    <= mem_wdata;
            mem_written[mem_addr] <= 1'b1;
        end
        if (mem_rd_en) begin
            mem_rdata <= (mem_written[mem_addr] === 1'b1) ? mem_data[mem_addr] : pat(mem_addr);
        end
    end

    // Scoreboard and strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_wr_en || mem_rd_en) begin
                ntotal++;
                if ((mem_wr_en && mem_rd_en) !== 1'b0)
                    $display("FAIL strobe_excl: wr_en=%b rd_en=%b required not both", mem_wr_en, mem_rd_en);
                else
                    npass++;
            end
            if (mem_wr_en) wr_seen++;
            if (mem_rd_en) rd_log.push_back(mem_addr);
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                ntotal++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected: got addr=%h data=%h, none expected", rsp_addr, rsp_rdata);
                end else begin
                    logic [14:0] exp;
                    exp = sb.pop_front();
                    if ({rsp_addr, rsp_rdata} !== exp)
                        $display("FAIL rsp_data: got addr=%h data=%h required addr=%h data=%h",
                                 rsp_addr, rsp_rdata, exp[14:8], exp[7:0]);
                    else
                        npass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one read request through its accept edge and queues expected responses.
    task automatic issue_read(input logic [6:0] addr, input logic [3:0] len);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_len   = len;
        req_wdata = 8'hEE;
        for (int k = 0; k <= int'(len); k++) begin
            logic [6:0] a;
            a = addr + 7'(k);
            sb.push_back({a, shadow[a]});
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 7'h11;
        req_wdata = 8'h22;
        req_len   = 4'h0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            ntotal++;
            if ({req_ready, mem_wr_en, mem_rd_en, rsp_valid} !== 4'b0000)
                $display("FAIL reset_hold: ready/wr/rd/rsp=%b required 0000",
                         {req_ready, mem_wr_en, mem_rd_en, rsp_valid});
            else
                npass++;
        end
        ntotal++;
        if ({mem_addr, mem_wdata, rsp_rdata, rsp_addr} !== 30'h0)
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h raddr=%h required all 0",
                     mem_addr, mem_wdata, rsp_rdata, rsp_addr);
        else
            npass++;
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        ntotal++;
        if (req_ready !== 1'b1)
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        else
            npass++;
    endtask

    task automatic test_write();
        wr_seen   = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 7'h05;
        req_wdata = 8'hA5;
        shadow[7'h05] = 8'hA5;
        tick();
        req_valid = 1'b0;
        ntotal++;
        if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata, req_ready} !== {1'b1, 1'b0, 7'h05, 8'hA5, 1'b0})
            $display("FAIL wr_strobe: wr=%b rd=%b addr=%h wdata=%h ready=%b required 1 0 05 a5 0",
                     mem_wr_en, mem_rd_en, mem_addr, mem_wdata, req_ready);
        else
            npass++;
        tick();
        ntotal++;
        if ({mem_wr_en, mem_wdata, req_ready, rsp_valid} !== {1'b0, 8'h00, 1'b1, 1'b0})
            $display("FAIL wr_done: wr=%b wdata=%h ready=%b rsp_valid=%b required 0 00 1 0",
                     mem_wr_en, mem_wdata, req_ready, rsp_valid);
        else
            npass++;
        tick();
        ntotal++;
        if ({wr_seen, rsp_valid} !== {32'd1, 1'b0})
            $display("FAIL wr_count: strobes=%0d rsp_valid=%b required 1 0", wr_seen, rsp_valid);
        else
            npass++;
    endtask

    task automatic test_single_read();
        rd_log.delete();
        rsp_ready = 1'b1;
        issue_read(7'h05, 4'h0);
        ntotal++;
        if ({mem_rd_en, mem_wr_en, mem_addr, rsp_valid} !== {1'b1, 1'b0, 7'h05, 1'b0})
            $display("FAIL rd_issue: rd=%b wr=%b addr=%h rsp_valid=%b required 1 0 05 0",
                     mem_rd_en, mem_wr_en, mem_addr, rsp_valid);
        else
            npass++;
        tick();
        ntotal++;
        if ({mem_rd_en, rsp_valid} !== 2'b00)
            $display("FAIL rd_wait: rd=%b rsp_valid=%b required 0 0", mem_rd_en, rsp_valid);
        else
            npass++;
        tick();
        ntotal++;
        if ({rsp_valid, rsp_rdata, rsp_addr} !== {1'b1, 8'hA5, 7'h05})
            $display("FAIL rd_rsp: valid=%b data=%h addr=%h required 1 a5 05",
                     rsp_valid, rsp_rdata, rsp_addr);
        else
            npass++;
        tick();
        ntotal++;
        if ({rsp_valid, req_ready, rd_log.size(), sb.size()} !== {1'b0, 1'b1, 32'd1, 32'd0})
            $display("FAIL rd_end: valid=%b ready=%b rd_strobes=%0d pending=%0d required 0 1 1 0",
                     rsp_valid, req_ready, rd_log.size(), sb.size());
        else
            npass++;
    endtask

    task automatic test_burst();
        int n;
        int base_rsp;
        rd_log.delete();
        base_rsp  = rsp_seen;
        rsp_ready = 1'b1;
        issue_read(7'h7E, 4'h3);
        n = 0;
        while (!(req_ready && sb.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        ntotal++;
        if (n >= 200)
            $display("FAIL burst_timeout: pending=%0d after %0d cycles, required 0", sb.size(), n);
        else
            npass++;
        ntotal++;
        if (rd_log.size() != 4 || rd_log[0] !== 7'h7E || rd_log[1] !== 7'h7F ||
            rd_log[2] !== 7'h00 || rd_log[3] !== 7'h01)
            $display("FAIL burst_addr: got %0d strobes first=%h required 7e 7f 00 01",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 7'h0);
        else
            npass++;
        ntotal++;
        if (rsp_seen - base_rsp !== 4)
            $display("FAIL burst_rsp_count: got %0d required 4", rsp_seen - base_rsp);
        else
            npass++;
`ifdef MEM_REQ_CTRL_STATS_EN
        ntotal++;
        if ({stat_wr_cnt, stat_rd_cnt} !== {16'd1, 16'd5})
            $display("FAIL stats_count: wr=%0d rd=%0d required 1 5", stat_wr_cnt, stat_rd_cnt);
        else
            npass++;
`endif
    endtask

    task automatic test_back_pressure();
        int n;
        int base_rsp;
        int log_n;
        logic [7:0] hold_data;
        logic [6:0] hold_addr;
        rd_log.delete();
        base_rsp  = rsp_seen;
        rsp_ready = 1'b1;
        issue_read(7'h7E, 4'h3);
        for (int c = 0; c < 4; c++) tick();
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        hold_data = rsp_rdata;
        hold_addr = rsp_addr;
        log_n     = rd_log.size();
        ntotal++;
        if ({rsp_valid, hold_addr, hold_data} !== {1'b1, 7'h7F, pat(7'h7F)})
            $display("FAIL stall_beat1: valid=%b addr=%h data=%h required 1 7f %h",
                     rsp_valid, hold_addr, hold_data, pat(7'h7F));
        else
            npass++;
        for (int c = 0; c < 5; c++) begin
            tick();
            ntotal++;
            if ({rsp_valid, rsp_addr, rsp_rdata, mem_rd_en} !== {1'b1, hold_addr, hold_data, 1'b0})
                $display("FAIL stall_hold: valid=%b addr=%h data=%h rd=%b required 1 %h %h 0",
                         rsp_valid, rsp_addr, rsp_rdata, mem_rd_en, hold_addr, hold_data);
            else
                npass++;
        end
        ntotal++;
        if (rd_log.size() !== log_n)
            $display("FAIL stall_no_issue: rd_strobes=%0d required %0d", rd_log.size(), log_n);
        else
            npass++;
        rsp_ready = 1'b1;
        n = 0;
        while (!(req_ready && sb.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        ntotal++;
        if (n >= 200 || rsp_seen - base_rsp !== 4 || rd_log.size() != 4 || rd_log[3] !== 7'h01)
            $display("FAIL stall_finish: responses=%0d strobes=%0d required 4 4",
                     rsp_seen - base_rsp, rd_log.size());
        else
            npass++;
    endtask

    task automatic test_reset_mid_burst();
        int log_n;
        rsp_ready = 1'b1;
        issue_read(7'h10, 4'h3);
        for (int c = 0; c < 6; c++) tick();
        ntotal++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 7'h12})
            $display("FAIL mid_beat2: rd=%b addr=%h required 1 12", mem_rd_en, mem_addr);
        else
            npass++;
        rst = 1'b0;
        tick();
        ntotal++;
        if ({mem_rd_en, mem_wr_en, rsp_valid, req_ready, mem_addr} !== {4'b0000, 7'h00})
            $display("FAIL mid_reset: rd=%b wr=%b rsp_valid=%b ready=%b addr=%h required 0 0 0 0 00",
                     mem_rd_en, mem_wr_en, rsp_valid, req_ready, mem_addr);
        else
            npass++;
        ntotal++;
        if (sb.size() !== 2)
            $display("FAIL mid_pending: got %0d undelivered beats required 2", sb.size());
        else
            npass++;
        sb.delete();
        rst = 1'b1;
        #1;
        ntotal++;
        if (req_ready !== 1'b1)
            $display("FAIL mid_release_ready: got %b required 1", req_ready);
        else
            npass++;
`ifdef MEM_REQ_CTRL_STATS_EN
        ntotal++;
        if ({stat_wr_cnt, stat_rd_cnt} !== 32'h0)
            $display("FAIL stats_reset: wr=%0d rd=%0d required 0 0", stat_wr_cnt, stat_rd_cnt);
        else
            npass++;
`endif
        log_n = rd_log.size();
        for (int c = 0; c < 8; c++) tick();
        ntotal++;
        if ({rd_log.size() == log_n, rsp_valid, req_ready} !== 3'b101)
            $display("FAIL mid_abandon: new_strobes=%0d rsp_valid=%b ready=%b required 0 0 1",
                     rd_log.size() - log_n, rsp_valid, req_ready);
        else
            npass++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) shadow[i] = pat(7'(i));
        test_reset();
        test_write();
        test_single_read();
        test_burst();
        test_back_pressure();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
